// File: rtl/nn_pkg.sv
// nn_pkg: shared widths, fixed-point format and argmax FSM states for the nn layers
package nn_pkg;
    localparam int DATA_W      = 20;
    localparam int NUM_CLASSES = 9;
    localparam int IDX_W       = 4;
    localparam int FRAC_W      = 12;
    localparam int INT_W       = DATA_W - FRAC_W;
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
endpackage

// File: rtl/nn_argmax_cmp.sv
// nn_argmax_cmp: one signed compare step of a running argmax; ties keep the incumbent
module nn_argmax_cmp #(
    parameter int DATA_W = 20,
    parameter int IDX_W  = 4
) (
    input  logic signed [DATA_W-1:0] cand,
    input  logic [IDX_W-1:0]         cand_idx,
    input  logic signed [DATA_W-1:0] best,
    input  logic [IDX_W-1:0]         best_idx,
    output logic signed [DATA_W-1:0] new_best,
    output logic [IDX_W-1:0]         new_idx
);
    logic take;
    assign take     = cand > best;
    assign new_best = take ? cand : best;
    assign new_idx  = take ? cand_idx : best_idx;
endmodule

// File: rtl/nn_argmax_seq.sv
// nn_argmax_seq: serial argmax over nine activations with reject flag; NN_ARGMAX_SCORE_EN adds max_val
module nn_argmax_seq #(
    parameter int                        DATA_W        = 20,
    parameter int                        NUM_CLASSES   = 9,
    parameter logic signed [DATA_W-1:0]  REJECT_THRESH = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] a3_1,
    input  logic signed [DATA_W-1:0] a3_2,
    input  logic signed [DATA_W-1:0] a3_3,
    input  logic signed [DATA_W-1:0] a3_4,
    input  logic signed [DATA_W-1:0] a3_5,
    input  logic signed [DATA_W-1:0] a3_6,
    input  logic signed [DATA_W-1:0] a3_7,
    input  logic signed [DATA_W-1:0] a3_8,
    input  logic signed [DATA_W-1:0] a3_9,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0]               class_idx,
    output logic                     reject
`ifdef NN_ARGMAX_SCORE_EN
    ,output logic [DATA_W-1:0]       max_val
`endif
);
    import nn_pkg::*;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CLASSES - 1);

    state_t                   state;
    logic signed [DATA_W-1:0] bank [NUM_CLASSES];
    logic signed [DATA_W-1:0] best, new_best;
    logic [IDX_W-1:0]         idx, new_idx, cnt;

    nn_argmax_cmp #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_cmp (
        .cand     (bank[cnt]),
        .cand_idx (cnt),
        .best     (best),
        .best_idx (idx),
        .new_best (new_best),
        .new_idx  (new_idx)
    );

    // Accept a vector, fold one bank entry per cycle into best/idx, then hold the result until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            class_idx <= '0;
            reject    <= 1'b0;
            best      <= '0;
            idx       <= '0;
            cnt       <= '0;
            for (int i = 0; i < NUM_CLASSES; i++) bank[i] <= '0;
`ifdef NN_ARGMAX_SCORE_EN
            max_val   <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid && in_ready) begin
                    bank[0]  <= a3_1;
                    bank[1]  <= a3_2;
                    bank[2]  <= a3_3;
                    bank[3]  <= a3_4;
                    bank[4]  <= a3_5;
                    bank[5]  <= a3_6;
                    bank[6]  <= a3_7;
                    bank[7]  <= a3_8;
                    bank[8]  <= a3_9;
                    best     <= a3_1;
                    idx      <= '0;
                    cnt      <= IDX_W'(1);
                    in_ready <= 1'b0;
                    state    <= SCAN;
                end
                SCAN: begin
                    best <= new_best;
                    idx  <= new_idx;
                    cnt  <= cnt + IDX_W'(1);
                    if (cnt == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        class_idx <= new_idx;
                        reject    <= new_best < REJECT_THRESH;
`ifdef NN_ARGMAX_SCORE_EN
                        max_val   <= new_best;
`endif
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nn_argmax_seq.sv
// tb_nn_argmax_seq: randomized scoreboard bench for nn_argmax_seq (optionally with NN_ARGMAX_SCORE_EN)
module tb_nn_argmax_seq;
    typedef logic signed [19:0] vec_t [9];
    typedef struct {
        int idx;
        int rej;
        int mv;
        int acc;
    } exp_t;

    logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1, rnd_phase = 0;
    logic signed [19:0] a [9];
    logic in_ready, out_valid, reject;
    logic [3:0] class_idx;
`ifdef NN_ARGMAX_SCORE_EN
    logic [19:0] max_val;
`endif
    exp_t q[$];
    int n_checks = 0, n_fail = 0, cyc = 0;
    logic ov_prev = 0;

    nn_argmax_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a3_1(a[0]), .a3_2(a[1]), .a3_3(a[2]), .a3_4(a[3]), .a3_5(a[4]),
        .a3_6(a[5]), .a3_7(a[6]), .a3_8(a[7]), .a3_9(a[8]),
        .out_valid(out_valid), .out_ready(out_ready), .class_idx(class_idx), .reject(reject)
`ifdef NN_ARGMAX_SCORE_EN
        , .max_val(max_val)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference: highest value wins, first occurrence on ties, reject below zero threshold
    function automatic exp_t model(input vec_t v, input int acc);
        exp_t e;
        int bi = 0;
        for (int i = 1; i < 9; i++) if (int'(v[i]) > int'(v[bi])) bi = i;
        e.idx = bi;
        e.rej = (int'(v[bi]) < 0) ? 1 : 0;
        e.mv  = int'(v[bi]);
        e.acc = acc;
        return e;
    endfunction

    task automatic scramble();
        for (int i = 0; i < 9; i++) a[i] = 20'($urandom);
    endtask

    task automatic send(input vec_t v);
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("in_ready_wait", (t < 100) ? 1 : 0, 1);
        a = v;
        in_valid = 1;
        @(posedge clk);
        #1;
        in_valid = 0;
        q.push_back(model(v, cyc));
        scramble();
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() > 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("drain", q.size(), 0);
    endtask

    function automatic vec_t fill(input logic signed [19:0] others, input int i1,
                                  input logic signed [19:0] v1, input int i2,
                                  input logic signed [19:0] v2);
        vec_t v;
        for (int i = 0; i < 9; i++) v[i] = others;
        if (i1 >= 0) v[i1] = v1;
        if (i2 >= 0) v[i2] = v2;
        return v;
    endfunction

    // Monitor: latency on each new result, scoreboard compare on each handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && !ov_prev) begin
                if (q.size() == 0) check("unexpected_out", 1, 0);
                else check("latency", cyc - q[0].acc, 8);
            end
            if (out_valid && out_ready && q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                check("class_idx", int'(class_idx), e.idx);
                check("reject", int'(reject), e.rej);
`ifdef NN_ARGMAX_SCORE_EN
                check("max_val", int'($signed(max_val)), e.mv);
`endif
            end
        end
        ov_prev = rst_n && out_valid;
    end

    always @(posedge clk) if (rnd_phase) begin
        #1;
        if (rnd_phase) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        vec_t v;
        exp_t e;
        int t;
        scramble();
        #12;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_class_idx", int'(class_idx), 0);
        check("rst_reject", int'(reject), 0);
        @(negedge clk);
        rst_n = 1;

        send(fill(20'sh00000, -1, 0, -1, 0));
        send(fill(20'shFF000, 4, 20'sh01000, -1, 0));
        send(fill(20'shF0000, 7, 20'shFFF00, -1, 0));
        send(fill(20'sh00000, 2, 20'sh00800, 7, 20'sh00800));
        send(fill(20'sh80000, -1, 0, -1, 0));
        drain();

        // Backpressure: result held, no new acceptance while DONE, none on the handshake edge
        out_ready = 0;
        v = fill(20'sh00010, 1, 20'sh00400, -1, 0);
        e = model(v, 0);
        send(v);
        t = 0;
        while (!out_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("bp_out_valid_wait", (t < 40) ? 1 : 0, 1);
        a = fill(20'sh7FFFF, -1, 0, -1, 0);
        in_valid = 1;
        repeat (5) begin
            @(negedge clk);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_class_idx", int'(class_idx), e.idx);
            check("bp_reject", int'(reject), e.rej);
        end
        @(posedge clk);
        #1;
        out_ready = 1;
        @(posedge clk);
        #1;
        check("bp_release_out_valid", int'(out_valid), 0);
        check("bp_release_in_ready", int'(in_ready), 1);
        in_valid = 0;
        repeat (12) @(negedge clk);
        check("bp_no_accept", int'(out_valid), 0);
        drain();

        // Reset mid-scan aborts immediately
        send(fill(20'sh00000, 3, 20'sh00100, -1, 0));
        repeat (4) @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_class_idx", int'(class_idx), 0);
        check("abort_in_ready", int'(in_ready), 1);
        q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1;
        send(fill(20'sh00020, 8, 20'sh00100, -1, 0));
        drain();

        // Random vectors with random consumer stalls
        rnd_phase = 1;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 9; i++) begin
                case ($urandom_range(0, 3))
                    0: v[i] = 20'sh80000;
                    1: v[i] = 20'sh7FFFF;
                    2: v[i] = 20'($signed($urandom_range(0, 4)) - 2);
                    default: v[i] = 20'($urandom);
                endcase
            end
            send(v);
        end
        drain();
        rnd_phase = 0;
        #2;
        out_ready = 1;
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
